lms_spi_mst: RTL and testbench

LMS_SPI_MST -- requirements
Module: lms_spi_mst

---
 rtl/lms_spi_mst.sv | 236 +++++++++++++++++++++++
 tb/tb_lms_spi_mst.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/lms_spi_mst.sv
// Purpose : single-word SPI master (modes 0-3, NUM_SS decoded selects, MSB-first;
//           optional LSB-first when LMS_SPI_MST_LSB_FIRST_EN is defined).
// Latency : rsp_valid pulses (2*DATA_W+2)*CLK_DIV+1 clk_clk cycles after the accept cycle.
// Backpressure: cmd_ready is high only while idle; one command is in flight at a time.
//
// Ports
//   clk_clk, reset_reset_n   : clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready      : command handshake; cmd_data/cmd_ss/cmd_mode latched on accept
//   cmd_mode                 : bit1 = CPOL, bit0 = CPHA
//   rsp_valid/rsp_data       : one-cycle completion pulse, received word held until next completion
//   busy                     : high from the cycle after accept through the rsp_valid cycle
//   spi_SCLK/MOSI/MISO/SS_n  : SPI bus; SS_n is active low, one line per slave
//   cmd_lsb_first            : present only with LMS_SPI_MST_LSB_FIRST_EN, selects LSB-first order
module lms_spi_mst #(
   parameter int DATA_W  = 16,
   parameter int NUM_SS  = 2,
   parameter int CLK_DIV = 2
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [DATA_W-1:0] cmd_data,
   input  logic [2:0]        cmd_ss,
   input  logic [1:0]        cmd_mode,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy,
   output logic              spi_SCLK,
   output logic              spi_MOSI,
   input  logic              spi_MISO,
   output logic [NUM_SS-1:0] spi_SS_n
`ifdef LMS_SPI_MST_LSB_FIRST_EN
   ,
   input  logic              cmd_lsb_first
`endif
);

   localparam int DIV_W  = $clog2(CLK_DIV) + 1;
   localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t              state_q;
   logic                cmd_ready_q;
   logic                busy_q;
   logic                rsp_valid_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                sclk_q;
   logic                mosi_q;
   logic [NUM_SS-1:0]   ss_n_q;
   logic                cpol_q;
   logic                cpha_q;
   logic [DATA_W-1:0]   tx_q;
   logic [DATA_W-1:0]   rx_q;
   logic [DIV_W-1:0]    div_cnt_q;
   // Index of the last SCLK edge produced in XFER; even = leading, odd = trailing.
   logic [EDGE_W-1:0]   edge_idx_q;

   logic                lsb_first;
   logic                lsb_first_in;
   logic                accept;
   logic                div_end;
   logic                tx_bit;
   logic                tx_first_bit;
   logic [DATA_W-1:0]   tx_d;
   logic [DATA_W-1:0]   tx_load_d;
   logic [DATA_W-1:0]   rx_d;

`ifdef LMS_SPI_MST_LSB_FIRST_EN
   logic lsb_first_q;
   assign lsb_first    = lsb_first_q;
   assign lsb_first_in = cmd_lsb_first;
`else
   assign lsb_first    = 1'b0;
   assign lsb_first_in = 1'b0;
`endif

   // Out-of-range slave indices decode to no active select; the transfer still runs.
   function automatic logic [NUM_SS-1:0] ss_decode(input logic [2:0] idx);
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int i = 0; i < NUM_SS; i++) begin
         if (idx == 3'(i)) begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

   assign accept  = cmd_valid && cmd_ready_q && (state_q == ST_IDLE);
   assign div_end = (div_cnt_q == DIV_LAST);

   // Shift-register next values. tx_q always holds the next bit to send at its
   // outgoing end, so MOSI updates are a single register load on a shift edge.
   always_comb begin
      tx_bit       = lsb_first ? tx_q[0] : tx_q[DATA_W-1];
      tx_first_bit = lsb_first_in ? cmd_data[0] : cmd_data[DATA_W-1];
      tx_d         = lsb_first ? {1'b0, tx_q[DATA_W-1:1]} : {tx_q[DATA_W-2:0], 1'b0};
      tx_load_d    = lsb_first_in ? (cmd_data >> 1) : (cmd_data << 1);
      rx_d         = lsb_first ? {spi_MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_MISO};
   end

   always_ff @(posedge clk_clk) begin
      if (!reset_reset_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         sclk_q      <= 1'b0;
         mosi_q      <= 1'b0;
         ss_n_q      <= '1;
         cpol_q      <= 1'b0;
         cpha_q      <= 1'b0;
         tx_q        <= '0;
         rx_q        <= '0;
         div_cnt_q   <= '0;
         edge_idx_q  <= '0;
`ifdef LMS_SPI_MST_LSB_FIRST_EN
         lsb_first_q <= 1'b0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               sclk_q <= cpol_q;
               if (accept) begin
                  state_q     <= ST_SETUP;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  div_cnt_q   <= '0;
                  cpol_q      <= cmd_mode[1];
                  cpha_q      <= cmd_mode[0];
                  sclk_q      <= cmd_mode[1];
                  ss_n_q      <= ss_decode(cmd_ss);
                  rx_q        <= '0;
`ifdef LMS_SPI_MST_LSB_FIRST_EN
                  lsb_first_q <= cmd_lsb_first;
`endif
                  // CPHA=0 slaves sample on the first edge, so the first bit
                  // must be on MOSI for the whole setup window.
                  if (!cmd_mode[0]) begin
                     mosi_q <= tx_first_bit;
                     tx_q   <= tx_load_d;
                  end else begin
                     tx_q   <= cmd_data;
                  end
               end else begin
                  cmd_ready_q <= 1'b1;
               end
            end

            ST_SETUP: begin
               div_cnt_q <= div_cnt_q + DIV_W'(1);
               if (div_end) begin
                  // Leaving setup produces leading edge 0.
                  state_q    <= ST_XFER;
                  div_cnt_q  <= '0;
                  edge_idx_q <= '0;
                  sclk_q     <= ~cpol_q;
                  if (cpha_q) begin
                     mosi_q <= tx_bit;
                     tx_q   <= tx_d;
                  end else begin
                     rx_q   <= rx_d;
                  end
               end
            end

            ST_XFER: begin
               div_cnt_q <= div_cnt_q + DIV_W'(1);
               if (div_end) begin
                  div_cnt_q <= '0;
                  if (edge_idx_q == EDGE_LAST) begin
                     // Last trailing half-period finished; SCLK is back at CPOL.
                     state_q <= ST_HOLD;
                  end else begin
                     edge_idx_q <= edge_idx_q + EDGE_W'(1);
                     sclk_q     <= ~sclk_q;
                     // Next edge is leading when the current index is odd.
                     // Leading edges shift for CPHA=1, trailing edges shift for CPHA=0.
                     if (edge_idx_q[0] == cpha_q) begin
                        mosi_q <= tx_bit;
                        tx_q   <= tx_d;
                     end else begin
                        rx_q   <= rx_d;
                     end
                  end
               end
            end

            ST_HOLD: begin
               div_cnt_q <= div_cnt_q + DIV_W'(1);
               if (div_end) begin
                  state_q     <= ST_DONE;
                  div_cnt_q   <= '0;
                  ss_n_q      <= '1;
                  rsp_data_q  <= rx_q;
                  rsp_valid_q <= 1'b1;
               end
            end

            ST_DONE: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end

            default: begin
               state_q     <= ST_IDLE;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b0;
               ss_n_q      <= '1;
            end
         endcase
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign spi_SCLK  = sclk_q;
   assign spi_MOSI  = mosi_q;
   assign spi_SS_n  = ss_n_q;

endmodule

// File: tb/tb_lms_spi_mst.sv
// Purpose : directed self-checking bench for lms_spi_mst (DATA_W=16, NUM_SS=2, CLK_DIV=2).
// Latency : expects rsp_valid 69 cycles after the accept cycle.
// Backpressure: commands are only issued while cmd_ready is high (or held valid across a transfer).
module tb_lms_spi_mst;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_data;
   logic [2:0]  cmd_ss;
   logic [1:0]  cmd_mode;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic        busy;
   logic        spi_SCLK;
   logic        spi_MOSI;
   logic        spi_MISO;
   logic [1:0]  spi_SS_n;
   logic        miso_loop;
   logic        miso_tie;
`ifdef LMS_SPI_MST_LSB_FIRST_EN
   logic        cmd_lsb_first;
`endif

   int checks = 0;
   int errors = 0;

   assign spi_MISO = miso_loop ? spi_MOSI : miso_tie;

   lms_spi_mst #(.DATA_W(16), .NUM_SS(2), .CLK_DIV(2)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_data      (cmd_data),
      .cmd_ss        (cmd_ss),
      .cmd_mode      (cmd_mode),
      .rsp_valid     (rsp_valid),
      .rsp_data      (rsp_data),
      .busy          (busy),
      .spi_SCLK      (spi_SCLK),
      .spi_MOSI      (spi_MOSI),
      .spi_MISO      (spi_MISO),
      .spi_SS_n      (spi_SS_n)
`ifdef LMS_SPI_MST_LSB_FIRST_EN
      ,
      .cmd_lsb_first (cmd_lsb_first)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issues one command at a negedge of an idle cycle and watches 70 cycles.
   // Returns at the negedge of the cycle after DONE (idle again).
   task automatic do_xfer(input logic [15:0] data, input logic [2:0] ss, input logic [1:0] mode,
                          input logic lsb, input logic keep, input logic [15:0] exp_rx,
                          input string tag);
      logic [1:0]  exp_ss;
      logic [1:0]  ss69;
      logic [15:0] exp_cap;
      logic [15:0] cap;
      logic        prev_sclk;
      logic        first_mosi;
      int          rsp_k, rsp_n, ss_bad, rdy_bad, busy_bad, rises, falls;
      exp_ss = (ss < 3'd2) ? ~(2'b01 << ss[0]) : 2'b11;
      for (int i = 0; i < 16; i++) exp_cap[i] = lsb ? data[15-i] : data[i];
      cap = '0; prev_sclk = 1'b0; first_mosi = 1'b0; ss69 = 2'b00;
      rsp_k = 0; rsp_n = 0; ss_bad = 0; rdy_bad = 0; busy_bad = 0; rises = 0; falls = 0;

      check({tag, ".ready_at_issue"}, cmd_ready, 1);
      cmd_valid = 1'b1; cmd_data = data; cmd_ss = ss; cmd_mode = mode;
`ifdef LMS_SPI_MST_LSB_FIRST_EN
      cmd_lsb_first = lsb;
`endif
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         if (k == 1) begin
            first_mosi = spi_MOSI;
            prev_sclk  = spi_SCLK;
            if (!keep) begin
               // Inputs change after accept; the DUT must use its latched copy.
               cmd_valid = 1'b0; cmd_data = ~data; cmd_ss = ~ss; cmd_mode = ~mode;
            end
         end else begin
            if (spi_SCLK !== prev_sclk) begin
               if (spi_SCLK) rises++; else falls++;
               // Slave-side sample edge: leading for CPHA=0, trailing for CPHA=1.
               if ((spi_SCLK != mode[1]) == (mode[0] == 1'b0)) cap = {cap[14:0], spi_MOSI};
            end
            prev_sclk = spi_SCLK;
         end
         if (rsp_valid === 1'b1) begin rsp_n++; rsp_k = k; end
         if (k <= 68 && spi_SS_n !== exp_ss) ss_bad++;
         if (k == 69) ss69 = spi_SS_n;
         if (k <= 69 && cmd_ready !== 1'b0) rdy_bad++;
         if (k <= 69 && busy !== 1'b1) busy_bad++;
      end
      check({tag, ".rsp_pulses"}, rsp_n, 1);
      check({tag, ".rsp_cycle"}, rsp_k, 69);
      check({tag, ".ss_during"}, ss_bad, 0);
      check({tag, ".ss_done"}, ss69, 2'b11);
      check({tag, ".ready_low_busy"}, rdy_bad, 0);
      check({tag, ".busy_high"}, busy_bad, 0);
      check({tag, ".busy_after"}, busy, 0);
      check({tag, ".ready_after"}, cmd_ready, 1);
      check({tag, ".sclk_rises"}, rises, 16);
      check({tag, ".sclk_falls"}, falls, 16);
      check({tag, ".sclk_idle"}, spi_SCLK, mode[1]);
      check({tag, ".mosi_bits"}, cap, exp_cap);
      check({tag, ".rsp_data"}, rsp_data, exp_rx);
      if (!mode[0]) check({tag, ".first_mosi"}, first_mosi, lsb ? data[0] : data[15]);
   endtask

   initial begin
      int rv_cnt;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = '0; cmd_ss = '0; cmd_mode = '0;
      miso_loop = 1'b1; miso_tie = 1'b0;
`ifdef LMS_SPI_MST_LSB_FIRST_EN
      cmd_lsb_first = 1'b0;
`endif
      // Reset state
      repeat (3) @(negedge clk);
      check("reset.cmd_ready", cmd_ready, 0);
      check("reset.busy", busy, 0);
      check("reset.rsp_valid", rsp_valid, 0);
      check("reset.rsp_data", rsp_data, 16'h0000);
      check("reset.sclk", spi_SCLK, 0);
      check("reset.mosi", spi_MOSI, 0);
      check("reset.ss_n", spi_SS_n, 2'b11);
      rst_n = 1'b1;
      @(negedge clk);
      check("release.cmd_ready", cmd_ready, 1);
      check("release.sclk", spi_SCLK, 0);

      // Mode 0, slave 1, loopback
      miso_loop = 1'b1;
      do_xfer(16'hA5C3, 3'd1, 2'b00, 1'b0, 1'b0, 16'hA5C3, "m0_ss1");

      // Mode 3, slave 0, MISO tied high; SCLK must idle high afterward
      miso_loop = 1'b0; miso_tie = 1'b1;
      do_xfer(16'h5A3C, 3'd0, 2'b11, 1'b0, 1'b0, 16'hFFFF, "m3_ss0");
      repeat (5) @(negedge clk);
      check("m3_ss0.sclk_idle_later", spi_SCLK, 1);
      check("m3_ss0.rsp_data_held", rsp_data, 16'hFFFF);

      // Two commands with cmd_valid held high: second accepted right after DONE
      miso_loop = 1'b1;
      do_xfer(16'h1234, 3'd0, 2'b01, 1'b0, 1'b1, 16'h1234, "b2b_first");
      miso_loop = 1'b0; miso_tie = 1'b0;
      do_xfer(16'hBEEF, 3'd1, 2'b10, 1'b0, 1'b0, 16'h0000, "b2b_second");

      // Out-of-range slave index: no select, full transfer still runs
      miso_loop = 1'b1;
      do_xfer(16'h3C5A, 3'd3, 2'b01, 1'b0, 1'b0, 16'h3C5A, "ss3");

`ifdef LMS_SPI_MST_LSB_FIRST_EN
      do_xfer(16'h0001, 3'd0, 2'b00, 1'b1, 1'b0, 16'h0001, "lsb_first");
`endif

      // Reset 10 cycles after accept (mode 2 so SCLK is high before the reset)
      check("rst_mid.ready_at_issue", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_data = 16'h00FF; cmd_ss = 3'd0; cmd_mode = 2'b10;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) cmd_valid = 1'b0;
      end
      check("rst_mid.busy_before", busy, 1);
      check("rst_mid.ss_before", spi_SS_n, 2'b10);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_mid.ss_n", spi_SS_n, 2'b11);
      check("rst_mid.sclk", spi_SCLK, 0);
      check("rst_mid.rsp_valid", rsp_valid, 0);
      check("rst_mid.rsp_data", rsp_data, 16'h0000);
      check("rst_mid.busy", busy, 0);
      check("rst_mid.cmd_ready_in_reset", cmd_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid.ready_after_release", cmd_ready, 1);
      rv_cnt = 0;
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (rsp_valid !== 1'b0) rv_cnt++;
      end
      check("rst_mid.no_rsp_valid", rv_cnt, 0);
      check("rst_mid.rsp_data_after", rsp_data, 16'h0000);
      check("rst_mid.sclk_idle", spi_SCLK, 0);
      check("rst_mid.ss_idle", spi_SS_n, 2'b11);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
